// File: rtl/umem_pkg.sv
// Shared types and constants for the unified memory arbiter.
//   state_e    : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   grant_e    : which core port owns the current memory transaction
//   FUNC3_WORD : access size/sign used for instruction fetches (LW)
package umem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_DATA  = 1'b0,
    GRANT_FETCH = 1'b1
  } grant_e;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/umem_wait_counter.sv
// Wait-state counter for the unified memory arbiter.
// Counts the extra cycles a memory read needs beyond the issue cycle.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   load_i  : start a new count at 1 (issue cycle)
//   inc_i   : advance the count by one
//   clear_i : return to 0 (highest priority)
//   tc_o    : count has reached MEM_LATENCY-1
module umem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic inc_i,
  input  logic clear_i,
  output logic tc_o
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(1);
    end else if (inc_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (cnt_q == CW'(MEM_LATENCY - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port synchronous memory between
// the instruction-fetch port and the load/store port of the RV32 core.
// Optional feature macro: FAIR_ARB_EN (alternating grant when both ports
// request in the same IDLE cycle; otherwise data always wins).
//
// Ports
//   clk, rst (async, active-low)
//   Fetch : if_req, if_addr, if_flush -> if_done, if_rdata
//   Data  : d_req, d_we, d_func3, d_addr, d_wdata -> d_done, d_rdata
//   Status: busy (FSM not in IDLE)
//   Memory: mem_en, mem_we, mem_func3, mem_addr, mem_wdata <- mem_rdata
//
// Every transaction is IDLE -> ISSUE -> WAIT x (MEM_LATENCY-1) -> RESP -> IDLE,
// with the done pulse in the IDLE cycle after RESP; that IDLE cycle also
// samples the next request, giving one access every MEM_LATENCY+2 cycles.
module unified_mem_arbiter
  import umem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q;
  grant_e              grant_q;
  logic                cancel_q;
  logic                we_q;
  logic [2:0]          func3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                if_done_q;
  logic                d_done_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
`ifdef FAIR_ARB_EN
  grant_e              last_grant_q;
`endif

  logic fetch_ok;
  logic pick_fetch;
  logic pick_data;

  // A flush in IDLE only masks the fetch request for that cycle.
  always_comb begin
    fetch_ok   = if_req && !if_flush;
`ifdef FAIR_ARB_EN
    pick_fetch = fetch_ok && (!d_req || (last_grant_q == GRANT_DATA));
`else
    pick_fetch = fetch_ok && !d_req;
`endif
    pick_data  = d_req && !pick_fetch;
  end

  logic cnt_load;
  logic cnt_inc;
  logic cnt_clear;
  logic cnt_tc;

  assign cnt_load  = (state_q == ISSUE) && (MEM_LATENCY > 1);
  assign cnt_inc   = (state_q == WAIT) && !cnt_tc;
  assign cnt_clear = (state_q == WAIT) && cnt_tc;

  umem_wait_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_wait_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .clear_i (cnt_clear),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_DATA;
      cancel_q     <= 1'b0;
      we_q         <= 1'b0;
      func3_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
`ifdef FAIR_ARB_EN
      last_grant_q <= GRANT_DATA;
`endif
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;

      // Cancel is sticky for the rest of a fetch; the RESP branch below
      // clears it and, being later, takes precedence.
      if (if_flush && (grant_q == GRANT_FETCH) && (state_q != IDLE)) begin
        cancel_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (pick_data) begin
            addr_q   <= d_addr;
            we_q     <= d_we;
            func3_q  <= d_func3;
            wdata_q  <= d_wdata;
            grant_q  <= GRANT_DATA;
            mem_en_q <= 1'b1;
            mem_we_q <= d_we;
            state_q  <= ISSUE;
`ifdef FAIR_ARB_EN
            last_grant_q <= GRANT_DATA;
`endif
          end else if (pick_fetch) begin
            addr_q   <= if_addr;
            we_q     <= 1'b0;
            func3_q  <= FUNC3_WORD;
            wdata_q  <= '0;
            grant_q  <= GRANT_FETCH;
            mem_en_q <= 1'b1;
            state_q  <= ISSUE;
`ifdef FAIR_ARB_EN
            last_grant_q <= GRANT_FETCH;
`endif
          end
        end
        ISSUE: begin
          state_q <= (MEM_LATENCY > 1) ? WAIT : RESP;
        end
        WAIT: begin
          if (cnt_tc) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          cancel_q <= 1'b0;
          if (grant_q == GRANT_DATA) begin
            d_done_q <= 1'b1;
            if (!we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end else if (!cancel_q && !if_flush) begin
            if_rdata_q <= mem_rdata;
            if_done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_func3 = func3_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance with MEM_LATENCY=2
// and one with MEM_LATENCY=1 (back-to-back throughput).
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: MEM_LATENCY = 2
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_func3;
  logic        if_done, d_done, busy, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  // Instance B: MEM_LATENCY = 1
  logic        b_if_req, b_if_flush, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
  logic [2:0]  b_d_func3;
  logic        b_if_done, b_d_done, b_busy, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [2:0]  b_mem_func3;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_flush(b_if_flush),
    .if_done(b_if_done), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_func3(b_d_func3), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_done(b_d_done), .d_rdata(b_d_rdata), .busy(b_busy),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_func3(b_mem_func3), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory contents: 0x10 holds 0x13, every other word is {16'h5A5A, addr[15:0]}.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h10) ? 32'h13 : {16'h5A5A, a[15:0]};
  endfunction

  // Memory models: read data is valid only in the cycle MEM_LATENCY cycles
  // after the mem_en cycle, garbage otherwise.
  logic [31:0] pa, b_pa;
  int unsigned pc, b_pc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 0; pa <= '0;
    end else if (mem_en) begin
      pc <= 1; pa <= mem_addr;
    end else if (pc != 0 && pc < 15) begin
      pc <= pc + 1;
    end
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_pc <= 0; b_pa <= '0;
    end else if (b_mem_en) begin
      b_pc <= 1; b_pa <= b_mem_addr;
    end else if (b_pc != 0 && b_pc < 15) begin
      b_pc <= b_pc + 1;
    end
  end
  assign mem_rdata   = (pc == 2)   ? memval(pa)   : 32'hBAD0BAD0;
  assign b_mem_rdata = (b_pc == 1) ? memval(b_pa) : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instance-A transaction already presented on the inputs; records
  // the tick of the done pulse and the last mem_en cycle's strobes.
  task automatic run_single(input bit is_fetch, output int done_t, output int en_n,
                            output logic [31:0] en_addr, output logic [31:0] en_wdata,
                            output logic en_we, output logic [2:0] en_f3);
    done_t = -1; en_n = 0; en_addr = '0; en_wdata = '0; en_we = 1'b0; en_f3 = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (mem_en) begin
        en_n++; en_addr = mem_addr; en_wdata = mem_wdata; en_we = mem_we; en_f3 = mem_func3;
      end
      if (is_fetch ? if_done : d_done) begin
        done_t = i; if_req = 1'b0; d_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 0; if_flush = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_func3 = '0;
    b_if_req = 0; b_if_flush = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0; b_d_func3 = '0;
    tick(); tick();
    n_cmp++; if ({busy, mem_en, mem_we, if_done, d_done} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, mem_en, mem_we, if_done, d_done}); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata}); end
    n_cmp++; if ({b_busy, b_mem_en, b_if_done, b_d_done} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl_b: got %b expected 0000", {b_busy, b_mem_en, b_if_done, b_d_done}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int t, n; logic [31:0] a, w; logic we; logic [2:0] f3;
    if_addr = 32'h10; if_req = 1'b1;
    run_single(1'b1, t, n, a, w, we, f3);
    n_cmp++; if (t !== 4) begin n_bad++; $display("FAIL fetch_done_tick: got %0d expected 4", t); end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL fetch_en_pulses: got %0d expected 1", n); end
    n_cmp++; if ({we, f3, a} !== {1'b0, 3'b010, 32'h10}) begin
      n_bad++; $display("FAIL fetch_mem_cmd: got we=%b f3=%b addr=%h expected we=0 f3=010 addr=00000010", we, f3, a); end
    n_cmp++; if (if_rdata !== 32'h13) begin n_bad++; $display("FAIL fetch_rdata: got %h expected 00000013", if_rdata); end
    tick();
    n_cmp++; if ({if_done, busy} !== 2'b00) begin n_bad++; $display("FAIL fetch_after: got %b expected 00", {if_done, busy}); end
  endtask

  task automatic test_load();
    int t, n; logic [31:0] a, w; logic we; logic [2:0] f3;
    d_addr = 32'h200; d_we = 1'b0; d_func3 = 3'b100; d_req = 1'b1;
    run_single(1'b0, t, n, a, w, we, f3);
    n_cmp++; if (t !== 4) begin n_bad++; $display("FAIL load_done_tick: got %0d expected 4", t); end
    n_cmp++; if ({n, we, f3, a} !== {32'd1, 1'b0, 3'b100, 32'h200}) begin
      n_bad++; $display("FAIL load_mem_cmd: got n=%0d we=%b f3=%b addr=%h expected n=1 we=0 f3=100 addr=00000200", n, we, f3, a); end
    n_cmp++; if (d_rdata !== 32'h5A5A0200) begin n_bad++; $display("FAIL load_rdata: got %h expected 5a5a0200", d_rdata); end
    n_cmp++; if (if_rdata !== 32'h13) begin n_bad++; $display("FAIL load_if_rdata_kept: got %h expected 00000013", if_rdata); end
    tick();
  endtask

  task automatic test_store();
    int t, n; logic [31:0] a, w; logic we; logic [2:0] f3;
    d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_func3 = 3'b010; d_req = 1'b1;
    run_single(1'b0, t, n, a, w, we, f3);
    d_we = 1'b0;
    n_cmp++; if (t !== 4) begin n_bad++; $display("FAIL store_done_tick: got %0d expected 4", t); end
    n_cmp++; if ({n, we, f3, a, w} !== {32'd1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL store_mem_cmd: got n=%0d we=%b f3=%b addr=%h wdata=%h expected 1 1 010 00000100 deadbeef", n, we, f3, a, w); end
    n_cmp++; if (d_rdata !== 32'h5A5A0200) begin n_bad++; $display("FAIL store_rdata_kept: got %h expected 5a5a0200", d_rdata); end
    tick();
  endtask

  task automatic test_priority();
    int dt, it, en_n; logic [31:0] a1, a2;
    dt = -1; it = -1; en_n = 0; a1 = '0; a2 = '0;
    if_addr = 32'h20; if_req = 1'b1;
    d_addr = 32'h300; d_we = 1'b0; d_func3 = 3'b010; d_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (mem_en) begin
        en_n++;
        if (en_n == 1) a1 = mem_addr; else a2 = mem_addr;
      end
      if (d_done) begin dt = i; d_req = 1'b0; end
      if (if_done) begin it = i; if_req = 1'b0; end
      if (dt > 0 && it > 0) break;
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef FAIR_ARB_EN
    n_cmp++; if ({a1, a2} !== {32'h20, 32'h300}) begin
      n_bad++; $display("FAIL prio_order: got %h,%h expected 00000020,00000300", a1, a2); end
    n_cmp++; if ({it, dt} !== {32'd4, 32'd8}) begin
      n_bad++; $display("FAIL prio_done_ticks: got if=%0d d=%0d expected if=4 d=8", it, dt); end
`else
    n_cmp++; if ({a1, a2} !== {32'h300, 32'h20}) begin
      n_bad++; $display("FAIL prio_order: got %h,%h expected 00000300,00000020", a1, a2); end
    n_cmp++; if ({dt, it} !== {32'd4, 32'd8}) begin
      n_bad++; $display("FAIL prio_done_ticks: got d=%0d if=%0d expected d=4 if=8", dt, it); end
`endif
    n_cmp++; if ({en_n, if_rdata, d_rdata} !== {32'd2, 32'h5A5A0020, 32'h5A5A0300}) begin
      n_bad++; $display("FAIL prio_data: got n=%0d if=%h d=%h expected 2 5a5a0020 5a5a0300", en_n, if_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_flush();
    int en_n, t, n; bit seen; logic busy4; logic [31:0] a, w; logic we; logic [2:0] f3;
    en_n = 0; seen = 0; busy4 = 1'bx;
    if_addr = 32'h40; if_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_en) en_n++;
      if (if_done) seen = 1;
      if (i == 4) busy4 = busy;
      if (i == 2) begin if_flush = 1'b1; if_req = 1'b0; end
      else if_flush = 1'b0;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_done: got %b expected 0", seen); end
    n_cmp++; if (if_rdata !== 32'h5A5A0020) begin n_bad++; $display("FAIL flush_rdata_kept: got %h expected 5a5a0020", if_rdata); end
    n_cmp++; if ({busy4, en_n} !== {1'b0, 32'd1}) begin
      n_bad++; $display("FAIL flush_idle: got busy=%b en=%0d expected busy=0 en=1", busy4, en_n); end
    // Flush while idle only blocks sampling for that one cycle
    if_addr = 32'h44; if_req = 1'b1; if_flush = 1'b1;
    tick();
    n_cmp++; if ({busy, mem_en} !== 2'b00) begin n_bad++; $display("FAIL flush_idle_block: got %b expected 00", {busy, mem_en}); end
    if_flush = 1'b0;
    run_single(1'b1, t, n, a, w, we, f3);
    n_cmp++; if ({t, if_rdata} !== {32'd4, 32'h5A5A0044}) begin
      n_bad++; $display("FAIL flush_refetch: got t=%0d rdata=%h expected t=4 rdata=5a5a0044", t, if_rdata); end
    tick();
    // Flush must not affect a data transaction
    d_addr = 32'h400; d_we = 1'b0; d_req = 1'b1; if_flush = 1'b1;
    run_single(1'b0, t, n, a, w, we, f3);
    if_flush = 1'b0;
    n_cmp++; if ({t, d_rdata} !== {32'd4, 32'h5A5A0400}) begin
      n_bad++; $display("FAIL flush_data_unaffected: got t=%0d rdata=%h expected t=4 rdata=5a5a0400", t, d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    int t, n; logic [31:0] a, w; logic we; logic [2:0] f3;
    d_addr = 32'h500; d_we = 1'b0; d_func3 = 3'b010; d_req = 1'b1;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_busy: got %b expected 1", busy); end
    rst = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++; if ({busy, mem_en, d_done, d_rdata} !== 35'h0) begin
      n_bad++; $display("FAIL rstmid_drop: got busy=%b en=%b done=%b rdata=%h expected all 0", busy, mem_en, d_done, d_rdata); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if ({busy, d_done} !== 2'b00) begin n_bad++; $display("FAIL rstmid_abandoned: got %b expected 00", {busy, d_done}); end
    d_addr = 32'h600; d_req = 1'b1;
    run_single(1'b0, t, n, a, w, we, f3);
    n_cmp++; if ({t, n, d_rdata} !== {32'd4, 32'd1, 32'h5A5A0600}) begin
      n_bad++; $display("FAIL rstmid_recover: got t=%0d n=%0d rdata=%h expected 4 1 5a5a0600", t, n, d_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int dt[3]; logic [31:0] rd[3]; int k, en_n;
    k = 0; en_n = 0;
    for (int j = 0; j < 3; j++) begin dt[j] = -1; rd[j] = '0; end
    b_d_addr = 32'h700; b_d_we = 1'b0; b_d_func3 = 3'b010; b_d_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (b_mem_en) en_n++;
      if (b_d_done) begin
        dt[k] = i; rd[k] = b_d_rdata; k++;
        if (k == 3) begin b_d_req = 1'b0; break; end
        b_d_addr = b_d_addr + 32'd4;
      end
    end
    b_d_req = 1'b0;
    n_cmp++; if ({dt[0], dt[1], dt[2]} !== {32'd3, 32'd6, 32'd9}) begin
      n_bad++; $display("FAIL b2b_done_ticks: got %0d,%0d,%0d expected 3,6,9", dt[0], dt[1], dt[2]); end
    n_cmp++; if ({rd[0], rd[1], rd[2]} !== {32'h5A5A0700, 32'h5A5A0704, 32'h5A5A0708}) begin
      n_bad++; $display("FAIL b2b_rdata: got %h,%h,%h expected 5a5a0700,5a5a0704,5a5a0708", rd[0], rd[1], rd[2]); end
    n_cmp++; if (en_n !== 3) begin n_bad++; $display("FAIL b2b_en_pulses: got %0d expected 3", en_n); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_priority();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Parametrised arbiter that shares one single-port synchronous memory between the instruction-fetch port and the data (load/store) port of the pipelined RV32 core.
- Replaces the combinational address-steering used for the single unified memory.
- Adds request/done handshakes, a configurable memory read latency, fetch flush, and optional fair arbitration.
- Sits between the core (IF and MEM stages) and the memory macro.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_en issue cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  cancel the outstanding fetch (branch/jump taken).
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction, registered, held until the next if_done.
- d_req  in  1  data request; held high with d_* inputs stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_func3  in  3  access size/sign, passed to the memory.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data, registered, held until the next d_done.
- busy  out  1  high in any state other than IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_func3  out  3  size/sign sent to the memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples requests at the rising edge.
  - If d_req: capture d_addr/d_we/d_func3/d_wdata, set grant=DATA, go to ISSUE.
  - Else if if_req and !if_flush: capture if_addr, func3=3'b010, we=0, grant=FETCH, go to ISSUE.
  - Else stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=captured we; mem_addr/mem_wdata/mem_func3 driven from the capture registers.
  - Go to WAIT if MEM_LATENCY>1, else to RESP.
- WAIT: counter runs 1..MEM_LATENCY-1; mem_en=0; mem_addr is held. Go to RESP when the count reaches MEM_LATENCY-1.
- RESP (1 cycle):
  - mem_rdata is valid this cycle and is registered into d_rdata or if_rdata per grant.
  - The matching done pulses in the following cycle, which is IDLE.
- Timing: req sampled at edge k → done high during cycle k+MEM_LATENCY+2. Stores complete with the same timing; d_rdata is not updated on a store.
- Back-to-back: a request still high in the done cycle is re-sampled in that same IDLE cycle. Sustained throughput is one access per MEM_LATENCY+2 cycles.
- Outside ISSUE, mem_en=0 and mem_we=0.
- Flush:
  - if_flush high in any cycle while grant=FETCH and the state is not IDLE sets a cancel flag.
  - The memory access completes, if_rdata is not updated, and if_done is suppressed.
  - if_flush has no effect on a data transaction.
  - A flush in IDLE blocks fetch sampling for that cycle only.
- Simultaneous d_req and if_req in IDLE: data wins (default).
- Reset (async, any state including mid-access):
  - FSM=IDLE, counter=0, cancel=0, grant=DATA.
  - All done pulses = 0, rdata registers = 0, mem_en=0, mem_we=0, busy=0.
  - The in-flight access is abandoned with no done.
- Counter width: $clog2(MEM_LATENCY+1).

Optional Feature:
- Macro: FAIR_ARB_EN.
- Defined:
  - A last_grant register is kept, reset value DATA.
  - When both requests are pending in IDLE and last_grant==DATA, the fetch is granted.
  - This bounds fetch starvation to one data access.
- Undefined: fixed data-over-fetch priority; last_grant is not instantiated.

Decomposition:
- Package umem_pkg: FSM state enum (IDLE/ISSUE/WAIT/RESP), grant enum (GRANT_DATA/GRANT_FETCH), FUNC3_WORD=3'b010 constant.
- One natural sub-module: umem_wait_counter (load/clear/terminal-count flag, parametrised by MEM_LATENCY).

Test Plan:
- MEM_LATENCY=2, fetch from 0x00000010 with mem_rdata=0x00000013 in RESP → exactly one mem_en pulse (mem_we=0) with addr 0x10; if_done high 4 cycles after the sampling edge; if_rdata=0x13.
- d_req store (d_we=1, addr 0x100, wdata 0xDEADBEEF, func3=010) → one cycle with mem_en=1, mem_we=1 and those values; d_done after MEM_LATENCY+2 cycles; d_rdata unchanged.
- if_req and d_req both high at the same edge, FAIR_ARB_EN undefined → data served first, fetch issued in the d_done cycle. With FAIR_ARB_EN defined and last_grant=DATA → fetch first.
- Fetch in flight, if_flush pulsed during WAIT → no if_done, if_rdata retains its old value, FSM back in IDLE after RESP.
- Assert rst=0 during WAIT of a load → busy, mem_en and d_done drop immediately. After rst=1, a new load completes normally with correct timing.
- MEM_LATENCY=1, 3 back-to-back loads with d_req held high → d_done every 3 cycles, each d_rdata matching its address.
